// File: rtl/bms_pkg.sv
// rtl/bms_pkg.sv - shared types and constants for the cell balance driver
package bms_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEAD_PRE  = 3'd1,
        BLEED     = 3'd2,
        DEAD_POST = 3'd3,
        COOL      = 3'd4,
        REQ       = 3'd5
    } state_t;

    localparam int CNT_W_DEF = 16;
    localparam int CELL0     = 0;
    localparam int CELL1     = 1;

    // Timer reload for a state lasting 'cyc' cycles; zero-length states still take one cycle.
    function automatic int unsigned load_val(input int unsigned cyc);
        return (cyc == 0) ? 0 : cyc - 1;
    endfunction

endpackage

// File: rtl/bal_timer.sv
// rtl/bal_timer.sv - loadable down-counter with a zero flag, holds at zero
module bal_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cell_balance_driver.sv
// rtl/cell_balance_driver.sv - bleed switch sequencer with dead time and cooldown; BAL_PWM_EN adds PWM bleed
module cell_balance_driver
    import bms_pkg::*;
#(
    parameter int DEAD_CYC  = 8,
    parameter int BLEED_CYC = 1000,
    parameter int COOL_CYC  = 200,
    parameter int CNT_W     = CNT_W_DEF
`ifdef BAL_PWM_EN
    ,
    parameter int PWM_DUTY  = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       done,
    input  logic       sel,
    input  logic       eqz,
    output logic       start,
    output logic [1:0] bal_en,
    output logic       busy,
    output logic       balanced
);

    localparam logic [CNT_W-1:0] LD_DEAD  = CNT_W'(load_val(DEAD_CYC));
    localparam logic [CNT_W-1:0] LD_BLEED = CNT_W'(load_val(BLEED_CYC));
    localparam logic [CNT_W-1:0] LD_COOL  = CNT_W'(load_val(COOL_CYC));

    state_t           state, next_state;
    logic             done_q, sel_q;
    logic             trigger;
    logic             t_load, t_zero;
    logic [CNT_W-1:0] t_val;
    logic             start_d, busy_d, balanced_d, bleed_on;
    logic [1:0]       bal_en_d;

`ifdef BAL_PWM_EN
    logic [2:0] phase, phase_d;
`endif

    assign trigger = enable && (state == IDLE) && done && !done_q;

    bal_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
            sel_q  <= 1'b0;
`ifdef BAL_PWM_EN
            phase  <= 3'd0;
`endif
        end else begin
            state  <= next_state;
            done_q <= done;
            if (trigger) begin
                sel_q <= sel;
            end
`ifdef BAL_PWM_EN
            phase  <= phase_d;
`endif
        end
    end

    // Dropping enable aborts from any state and parks the timer at zero.
    always_comb begin
        next_state = state;
        t_load     = 1'b0;
        t_val      = '0;
        if (!enable) begin
            next_state = IDLE;
            t_load     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        t_load     = 1'b1;
                        next_state = eqz ? COOL : DEAD_PRE;
                        t_val      = eqz ? LD_COOL : LD_DEAD;
                    end
                end
                DEAD_PRE: begin
                    if (t_zero) begin
                        next_state = BLEED;
                        t_load     = 1'b1;
                        t_val      = LD_BLEED;
                    end
                end
                BLEED: begin
                    if (t_zero) begin
                        next_state = DEAD_POST;
                        t_load     = 1'b1;
                        t_val      = LD_DEAD;
                    end
                end
                DEAD_POST: begin
                    if (t_zero) begin
                        next_state = COOL;
                        t_load     = 1'b1;
                        t_val      = LD_COOL;
                    end
                end
                COOL: begin
                    if (t_zero) begin
                        next_state = REQ;
                    end
                end
                REQ:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so each register lines up with its state.
    always_comb begin
        start_d    = (next_state == REQ);
        busy_d     = (next_state != IDLE);
        balanced_d = balanced;
        if (trigger && eqz) begin
            balanced_d = 1'b1;
        end
        if (state == DEAD_PRE && next_state == BLEED) begin
            balanced_d = 1'b0;
        end
`ifdef BAL_PWM_EN
        phase_d  = 3'd0;
        if (next_state == BLEED && state == BLEED) begin
            phase_d = phase + 3'd1;
        end
        bleed_on = (next_state == BLEED) && (int'(phase_d) < PWM_DUTY);
`else
        bleed_on = (next_state == BLEED);
`endif
        bal_en_d        = 2'b00;
        bal_en_d[CELL0] = bleed_on && !sel_q;
        bal_en_d[CELL1] = bleed_on && sel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start    <= 1'b0;
            bal_en   <= 2'b00;
            busy     <= 1'b0;
            balanced <= 1'b0;
        end else begin
            start    <= start_d;
            bal_en   <= bal_en_d;
            busy     <= busy_d;
            balanced <= balanced_d;
        end
    end

endmodule

// File: tb/tb_cell_balance_driver.sv
// tb/tb_cell_balance_driver.sv - self-checking bench for cell_balance_driver (BAL_PWM_EN selects PWM build)
module tb_cell_balance_driver;

    localparam int D = 2;
    localparam int C = 3;
`ifdef BAL_PWM_EN
    localparam int B         = 12;
    localparam int DUTY      = 3;
    localparam int EXP_START = 20;
    localparam int EXP_BLEED = 6;
`else
    localparam int B         = 5;
    localparam int DUTY      = 8;
    localparam int EXP_START = 13;
    localparam int EXP_BLEED = 5;
`endif

    logic       clk = 1'b0;
    logic       rst, enable, done, sel, eqz;
    logic       start, busy, balanced;
    logic [1:0] bal_en;

    int checks = 0;
    int passes = 0;

    cell_balance_driver #(
        .DEAD_CYC  (D),
        .BLEED_CYC (B),
        .COOL_CYC  (C),
        .CNT_W     (16)
`ifdef BAL_PWM_EN
        ,
        .PWM_DUTY  (DUTY)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .done     (done),
        .sel      (sel),
        .eqz      (eqz),
        .start    (start),
        .bal_en   (bal_en),
        .busy     (busy),
        .balanced (balanced)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: a round is a schedule of cycles counted from the trigger edge.
    bit m_active = 1'b0, m_eqz = 1'b0, m_sel = 1'b0, m_bal = 1'b0, m_done_q = 1'b0;
    int m_k = 0;

    function automatic int round_len(input bit e);
        return e ? (C + 1) : (2 * D + B + C + 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_eqz    <= 1'b0;
            m_sel    <= 1'b0;
            m_bal    <= 1'b0;
            m_done_q <= 1'b0;
            m_k      <= 0;
        end else begin
            m_done_q <= done;
            if (!enable) begin
                m_active <= 1'b0;
            end else if (!m_active) begin
                if (done && !m_done_q) begin
                    m_active <= 1'b1;
                    m_k      <= 1;
                    m_eqz    <= eqz;
                    m_sel    <= sel;
                    if (eqz) m_bal <= 1'b1;
                end
            end else begin
                if (m_k == round_len(m_eqz)) m_active <= 1'b0;
                else m_k <= m_k + 1;
                if (!m_eqz && m_k + 1 == D + 1) m_bal <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int exp_bal_en;
        bit win;
        win = m_active && !m_eqz && m_k >= D + 1 && m_k <= D + B
              && ((m_k - D - 1) % 8 < DUTY);
        exp_bal_en = win ? (m_sel ? 2 : 1) : 0;
        check("busy", int'(busy), int'(m_active));
        check("start", int'(start), int'(m_active && m_k == round_len(m_eqz)));
        check("bal_en", int'(bal_en), exp_bal_en);
        check("balanced", int'(balanced), int'(m_bal));
        check("bal_en_not_11", int'(bal_en == 2'b11), 0);
    end

    // mode 0: drop done after one cycle; 1: hold; 2: hold with extra pulses mid-round
    task automatic watch(input int limit, input int mode, output int t_start, output int n_pre,
                         output int n_on, output int n_st, output int last_on);
        bit seen;
        seen = 1'b0;
        t_start = -1; n_pre = 0; n_on = 0; n_st = 0; last_on = 0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (start) begin
                n_st++;
                if (t_start < 0) t_start = n;
            end
            if (bal_en != 2'b00) begin
                seen = 1'b1;
                n_on++;
                last_on = int'(bal_en);
            end else if (!seen) begin
                n_pre++;
            end
            if (mode == 0 && n == 1) done = 1'b0;
            if (mode == 2 && n >= 4 && n <= 7) done = (n % 2 == 1);
        end
    endtask

    initial begin
        int ts, np, non, nst, lo, bleed_seen, abort_n, st_after, aborted;
        int be_after, busy_after;
        rst = 1'b1; enable = 1'b0; done = 1'b0; sel = 1'b0; eqz = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_start", int'(start), 0);
        check("reset_bal_en", int'(bal_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_balanced", int'(balanced), 0);
        rst = 1'b0; enable = 1'b1;
        @(negedge clk);

        // bleed cell 1
        sel = 1'b1; eqz = 1'b0; done = 1'b1;
        watch(30, 0, ts, np, non, nst, lo);
        check("t1_start_latency", ts, EXP_START);
        check("t1_pre_dead", np, 2);
        check("t1_bleed_cycles", non, EXP_BLEED);
        check("t1_bleed_value", lo, 2);
        check("t1_start_count", nst, 1);
        check("t1_busy_after", int'(busy), 0);

        // equal SOC verdict
        sel = 1'b0; eqz = 1'b1; done = 1'b1;
        watch(10, 0, ts, np, non, nst, lo);
        check("t2_start_latency", ts, 4);
        check("t2_no_bleed", non, 0);
        check("t2_start_count", nst, 1);
        check("t2_balanced", int'(balanced), 1);

        // abort on third bleed cycle
        eqz = 1'b0; sel = 1'b0; done = 1'b1;
        bleed_seen = 0; abort_n = -1; st_after = 0; aborted = 0; be_after = -1; busy_after = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) done = 1'b0;
            if (start) st_after++;
            if (n == abort_n + 1 && aborted == 1) begin
                be_after = int'(bal_en);
                busy_after = int'(busy);
            end
            if (bal_en != 2'b00 && aborted == 0) begin
                bleed_seen++;
                if (bleed_seen == 3) begin
                    enable = 1'b0;
                    aborted = 1;
                    abort_n = n;
                end
            end
        end
        check("t3_aborted", aborted, 1);
        check("t3_bal_en_after", be_after, 0);
        check("t3_busy_after", busy_after, 0);
        check("t3_no_start", st_after, 0);
        check("t3_balanced_cleared", int'(balanced), 0);
        enable = 1'b1;
        @(negedge clk);
        done = 1'b1;
        watch(30, 0, ts, np, non, nst, lo);
        check("t3_restart_latency", ts, EXP_START);
        check("t3_restart_value", lo, 1);

        // done held high with extra pulses mid-round
        sel = 1'b0; done = 1'b1;
        watch(45, 2, ts, np, non, nst, lo);
        check("t4_start_latency", ts, EXP_START);
        check("t4_start_count", nst, 1);
        check("t4_bleed_cycles", non, EXP_BLEED);
        done = 1'b0;
        @(negedge clk);

        // asynchronous reset mid-bleed
        sel = 1'b1; done = 1'b1;
        bleed_seen = 0;
        for (int n = 1; n <= 20 && bleed_seen == 0; n++) begin
            @(negedge clk);
            if (n == 1) done = 1'b0;
            if (bal_en != 2'b00) bleed_seen = 1;
        end
        check("t5_reached_bleed", bleed_seen, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_bal_en", int'(bal_en), 0);
        check("t5_async_busy", int'(busy), 0);
        check("t5_async_start", int'(start), 0);
        check("t5_async_balanced", int'(balanced), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        done = 1'b1;
        watch(30, 0, ts, np, non, nst, lo);
        check("t5_post_reset_latency", ts, EXP_START);
        check("t5_post_reset_value", lo, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
